// File: rtl/option_parser_pkg.sv
// Shared types and defaults for the option frame parser and its field assembler.
package option_parser_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } parse_state_t;

    localparam int NUM_FIELDS_DEF = 7;
    localparam int FIELD_W_DEF    = 32;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Bits needed to hold the values 0 .. n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/option_frame_parser_field_assembler.sv
// Places payload bytes into the per-frame assembly register and keeps the byte count.
// With PARSE_CHECKSUM_EN defined it also keeps the running XOR of the payload.
module field_assembler
    import option_parser_pkg::*;
#(
    parameter int NUM_FIELDS = NUM_FIELDS_DEF,
    parameter int FIELD_W    = FIELD_W_DEF,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          load,
    input  logic [7:0]                    data_in,
    output logic [NUM_FIELDS*FIELD_W-1:0] asm_next,
`ifdef PARSE_CHECKSUM_EN
    output logic [7:0]                    xor_acc,
`endif
    output logic                          last_byte
);

    localparam int FIELD_BYTES = FIELD_W / 8;
    localparam int TOTAL_BYTES = NUM_FIELDS * FIELD_BYTES;
    localparam int CNT_W       = cnt_width(TOTAL_BYTES);
    localparam int OFF_W       = cnt_width(NUM_FIELDS * FIELD_W);

    logic [CNT_W-1:0]              byte_cnt;
    logic [NUM_FIELDS*FIELD_W-1:0] asm_q;
    logic [OFF_W-1:0]              bit_off;
    int unsigned                   fld;
    int unsigned                   pos;
    int unsigned                   lane;

    // asm_next already contains the byte being loaded, so a commit on the
    // last strobe sees the complete frame without an extra cycle.
    always_comb begin
        fld  = 32'(byte_cnt) / FIELD_BYTES;
        pos  = 32'(byte_cnt) % FIELD_BYTES;
        lane = MSB_FIRST ? (FIELD_BYTES - 1 - pos) : pos;
        bit_off = OFF_W'(fld * FIELD_W + lane * 8);
        asm_next = asm_q;
        if (load) begin
            asm_next[bit_off +: 8] = data_in;
        end
    end

    assign last_byte = (byte_cnt == CNT_W'(TOTAL_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
            asm_q    <= '0;
`ifdef PARSE_CHECKSUM_EN
            xor_acc  <= '0;
`endif
        end else if (clear) begin
            byte_cnt <= '0;
`ifdef PARSE_CHECKSUM_EN
            xor_acc  <= '0;
`endif
        end else if (load) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            asm_q    <= asm_next;
`ifdef PARSE_CHECKSUM_EN
            xor_acc  <= xor_acc ^ data_in;
`endif
        end
    end

endmodule

// File: rtl/option_frame_parser.sv
// Sync-hunting frame parser for the pricing engine: framing FSM, timeout, output hold, drop counting.
// Optional checksum byte after the payload when PARSE_CHECKSUM_EN is defined.
module option_frame_parser
    import option_parser_pkg::*;
#(
    parameter int         NUM_FIELDS  = NUM_FIELDS_DEF,
    parameter int         FIELD_W     = FIELD_W_DEF,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter bit         MSB_FIRST   = 1'b1,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          data_rdy,
    output logic [NUM_FIELDS*FIELD_W-1:0] fields_out,
    output logic                          data_out_rdy,
    input  logic                          data_out_ack,
    output logic                          frame_drop,
    output logic [15:0]                   err_cnt,
    output logic [1:0]                    state_dbg
);

    localparam int TMO_W = cnt_width(TIMEOUT_CYC);

    parse_state_t                  state;
    logic [TMO_W-1:0]              tmo_cnt;
    logic [NUM_FIELDS*FIELD_W-1:0] asm_next;
    logic                          last_byte;
    logic                          sof;
    logic                          load;
    logic                          frame_done;
    logic                          frame_ok;
    logic                          can_accept;
    logic                          commit;
    logic                          timeout_hit;
    logic                          drop;

    assign state_dbg = state;

    assign sof  = (state == HUNT) && data_rdy && (data_in == SYNC_BYTE);
    assign load = (state == PAYLOAD) && data_rdy;

    // A byte arriving in the same cycle always wins over the timeout.
    assign timeout_hit = (state != HUNT) && !data_rdy &&
                         (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

`ifdef PARSE_CHECKSUM_EN
    logic [7:0] xor_acc;
    assign frame_done = (state == CHECK) && data_rdy;
    assign frame_ok   = frame_done && (data_in == xor_acc);
`else
    assign frame_done = load && last_byte;
    assign frame_ok   = frame_done;
`endif

    // Output handshake: data_out_rdy is the valid, data_out_ack the ready.
    // A transfer happens on a cycle with both high; fields_out is frozen
    // while data_out_rdy is high, and a new frame may replace it only in
    // the cycle it is being accepted.
    assign can_accept = !data_out_rdy || data_out_ack;
    assign commit     = frame_ok && can_accept;
    assign drop       = timeout_hit || (frame_done && !commit);

    field_assembler #(
        .NUM_FIELDS (NUM_FIELDS),
        .FIELD_W    (FIELD_W),
        .MSB_FIRST  (MSB_FIRST)
    ) u_assembler (
        .clk       (clk),
        .rst       (rst),
        .clear     (sof),
        .load      (load),
        .data_in   (data_in),
        .asm_next  (asm_next),
`ifdef PARSE_CHECKSUM_EN
        .xor_acc   (xor_acc),
`endif
        .last_byte (last_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HUNT;
            tmo_cnt      <= '0;
            data_out_rdy <= 1'b0;
            fields_out   <= '0;
            frame_drop   <= 1'b0;
            err_cnt      <= '0;
        end else begin
            frame_drop <= drop;
            if (drop && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end

            if (commit) begin
                fields_out   <= asm_next;
                data_out_rdy <= 1'b1;
            end else if (data_out_ack) begin
                data_out_rdy <= 1'b0;
            end

            if (data_rdy || (state == HUNT)) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            case (state)
                HUNT: begin
                    if (sof) state <= PAYLOAD;
                end
                PAYLOAD: begin
                    if (load && last_byte) begin
`ifdef PARSE_CHECKSUM_EN
                        state <= CHECK;
`else
                        state <= HUNT;
`endif
                    end else if (timeout_hit) begin
                        state <= HUNT;
                    end
                end
                CHECK: begin
                    if (data_rdy || timeout_hit) state <= HUNT;
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_option_frame_parser.sv
// Directed bench for option_frame_parser: MSB- and LSB-first instances share one stimulus stream.
module tb_option_frame_parser;
    import option_parser_pkg::*;

    localparam int NF = 7;
    localparam int FW = 32;
    localparam int NB = NF * (FW / 8);

    logic clk = 1'b0;
    logic rst;
    logic [7:0] data_in;
    logic data_rdy;
    logic data_out_ack;

    logic [NF*FW-1:0] fields_out, fields_lsb;
    logic data_out_rdy, rdy_lsb;
    logic frame_drop, drop_lsb;
    logic [15:0] err_cnt, err_lsb;
    logic [1:0] state_dbg, state_lsb;

    int checks = 0;
    int errors = 0;
    int drop_cnt = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_drop === 1'b1) drop_cnt++;

    option_frame_parser u_dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_rdy(data_rdy),
        .fields_out(fields_out), .data_out_rdy(data_out_rdy), .data_out_ack(data_out_ack),
        .frame_drop(frame_drop), .err_cnt(err_cnt), .state_dbg(state_dbg)
    );

    option_frame_parser #(.MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .data_in(data_in), .data_rdy(data_rdy),
        .fields_out(fields_lsb), .data_out_rdy(rdy_lsb), .data_out_ack(data_out_ack),
        .frame_drop(drop_lsb), .err_cnt(err_lsb), .state_dbg(state_lsb)
    );

    function automatic logic [31:0] exp_field(input logic [7:0] base, input int k, input bit msb);
        logic [31:0] f;
        logic [7:0] b;
        f = '0;
        for (int j = 0; j < 4; j++) begin
            b = base + 8'(4 * k + j);
            if (msb) f = {f[23:0], b};
            else     f = {b, f[31:8]};
        end
        return f;
    endfunction

    task automatic apply_reset();
        rst = 1'b1; data_rdy = 1'b0; data_in = 8'h00; data_out_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        @(negedge clk);
        data_in = b;
        data_rdy = 1'b1;
    endtask

    task automatic end_bytes();
        @(negedge clk);
        data_rdy = 1'b0;
        data_in = 8'h00;
        data_out_ack = 1'b0;
    endtask

    task automatic send_payload(input logic [7:0] base, input int n);
        drive_byte(SYNC_BYTE_DEF);
        for (int i = 0; i < n; i++) drive_byte(base + 8'(i));
    endtask

    // Full frame; ack_last raises data_out_ack together with the final strobe.
    task automatic send_frame(input logic [7:0] base, input bit ack_last);
`ifdef PARSE_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
`endif
        drive_byte(SYNC_BYTE_DEF);
        for (int i = 0; i < NB; i++) begin
            drive_byte(base + 8'(i));
`ifdef PARSE_CHECKSUM_EN
            x = x ^ (base + 8'(i));
`else
            if (i == NB - 1) data_out_ack = ack_last;
`endif
        end
`ifdef PARSE_CHECKSUM_EN
        drive_byte(x);
        data_out_ack = ack_last;
`endif
        end_bytes();
    endtask

    task automatic do_ack();
        @(negedge clk); data_out_ack = 1'b1;
        @(negedge clk); data_out_ack = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++; if (data_out_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%b exp=0", data_out_rdy); end
        checks++; if (fields_out !== '0) begin errors++; $display("FAIL reset_fields got=%h exp=0", fields_out); end
        checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", frame_drop); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err got=%0d exp=0", err_cnt); end
        checks++; if (state_dbg !== 2'(HUNT)) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, HUNT); end
    endtask

    task automatic test_msb_first();
        send_frame(8'h01, 1'b0);
        checks++; if (data_out_rdy !== 1'b1) begin errors++; $display("FAIL msb_rdy_latency got=%b exp=1", data_out_rdy); end
        checks++; if (fields_out[0 +: FW] !== 32'h01020304) begin errors++; $display("FAIL msb_field0 got=%h exp=01020304", fields_out[0 +: FW]); end
        checks++; if (fields_out[6*FW +: FW] !== 32'h191A1B1C) begin errors++; $display("FAIL msb_field6 got=%h exp=191A1B1C", fields_out[6*FW +: FW]); end
        for (int k = 0; k < NF; k++) exp_q.push_back(exp_field(8'h01, k, 1'b1));
        for (int k = 0; k < NF; k++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++; if (fields_out[k*FW +: FW] !== e) begin errors++; $display("FAIL msb_field%0d got=%h exp=%h", k, fields_out[k*FW +: FW], e); end
        end
        do_ack();
        checks++; if (data_out_rdy !== 1'b0) begin errors++; $display("FAIL ack_clears_rdy got=%b exp=0", data_out_rdy); end
    endtask

    task automatic test_lsb_first();
        drive_byte(8'h00);
        drive_byte(8'hFF);
        send_frame(8'h01, 1'b0);
        checks++; if (rdy_lsb !== 1'b1) begin errors++; $display("FAIL lsb_rdy got=%b exp=1", rdy_lsb); end
        checks++; if (fields_lsb[0 +: FW] !== 32'h04030201) begin errors++; $display("FAIL lsb_field0 got=%h exp=04030201", fields_lsb[0 +: FW]); end
        checks++; if (fields_lsb[6*FW +: FW] !== 32'h1C1B1A19) begin errors++; $display("FAIL lsb_field6 got=%h exp=1C1B1A19", fields_lsb[6*FW +: FW]); end
        checks++; if (fields_out[0 +: FW] !== 32'h01020304) begin errors++; $display("FAIL garbage_msb_field0 got=%h exp=01020304", fields_out[0 +: FW]); end
        checks++; if (err_lsb !== 16'd0 || drop_lsb !== 1'b0) begin errors++; $display("FAIL garbage_no_drop err=%0d drop=%b exp=0/0", err_lsb, drop_lsb); end
        checks++; if (state_lsb !== 2'(HUNT)) begin errors++; $display("FAIL lsb_state got=%0d exp=%0d", state_lsb, HUNT); end
    endtask

    task automatic test_overflow();
        int d0;
        d0 = drop_cnt;
        send_frame(8'h41, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (drop_cnt !== d0 + 1) begin errors++; $display("FAIL ovf_drop_pulses got=%0d exp=%0d", drop_cnt - d0, 1); end
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL ovf_err got=%0d exp=1", err_cnt); end
        checks++; if (data_out_rdy !== 1'b1) begin errors++; $display("FAIL ovf_rdy_held got=%b exp=1", data_out_rdy); end
        checks++; if (fields_out[0 +: FW] !== 32'h01020304) begin errors++; $display("FAIL ovf_fields_kept got=%h exp=01020304", fields_out[0 +: FW]); end
        d0 = drop_cnt;
        send_frame(8'h61, 1'b1);
        checks++; if (data_out_rdy !== 1'b1) begin errors++; $display("FAIL ack_last_rdy got=%b exp=1", data_out_rdy); end
        checks++; if (fields_out[0 +: FW] !== 32'h61626364) begin errors++; $display("FAIL ack_last_field0 got=%h exp=61626364", fields_out[0 +: FW]); end
        checks++; if (fields_out[6*FW +: FW] !== 32'h797A7B7C) begin errors++; $display("FAIL ack_last_field6 got=%h exp=797A7B7C", fields_out[6*FW +: FW]); end
        repeat (2) @(negedge clk);
        checks++; if (drop_cnt !== d0 || err_cnt !== 16'd1) begin errors++; $display("FAIL ack_last_no_drop drops=%0d err=%0d exp=0/1", drop_cnt - d0, err_cnt); end
    endtask

    task automatic test_timeout();
        bit early;
        bit seen;
        int d0;
        apply_reset();
        d0 = drop_cnt;
        send_payload(8'h01, 10);
        end_bytes();
        early = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (frame_drop === 1'b1) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0", early); end
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (frame_drop === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL timeout_drop got=%b exp=1", seen); end
        repeat (2) @(negedge clk);
        checks++; if (err_cnt !== 16'd1 || drop_cnt !== d0 + 1) begin errors++; $display("FAIL timeout_err err=%0d drops=%0d exp=1/1", err_cnt, drop_cnt - d0); end
        checks++; if (data_out_rdy !== 1'b0 || state_dbg !== 2'(HUNT)) begin errors++; $display("FAIL timeout_state rdy=%b state=%0d exp=0/%0d", data_out_rdy, state_dbg, HUNT); end
        send_frame(8'h81, 1'b0);
        checks++; if (data_out_rdy !== 1'b1) begin errors++; $display("FAIL post_timeout_rdy got=%b exp=1", data_out_rdy); end
        checks++; if (fields_out[0 +: FW] !== 32'h81828384) begin errors++; $display("FAIL post_timeout_field0 got=%h exp=81828384", fields_out[0 +: FW]); end
        checks++; if (fields_out[6*FW +: FW] !== 32'h999A9B9C) begin errors++; $display("FAIL post_timeout_field6 got=%h exp=999A9B9C", fields_out[6*FW +: FW]); end
    endtask

`ifdef PARSE_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] x;
        int d0;
        do_ack();
        send_frame(8'h21, 1'b0);
        checks++; if (data_out_rdy !== 1'b1) begin errors++; $display("FAIL sum_good_rdy got=%b exp=1", data_out_rdy); end
        checks++; if (fields_out[0 +: FW] !== 32'h21222324) begin errors++; $display("FAIL sum_good_field0 got=%h exp=21222324", fields_out[0 +: FW]); end
        do_ack();
        d0 = drop_cnt;
        x = 8'h00;
        drive_byte(SYNC_BYTE_DEF);
        for (int i = 0; i < NB; i++) begin
            drive_byte(8'h31 + 8'(i));
            x = x ^ (8'h31 + 8'(i));
        end
        drive_byte(x ^ 8'h01);
        end_bytes();
        repeat (2) @(negedge clk);
        checks++; if (data_out_rdy !== 1'b0) begin errors++; $display("FAIL sum_bad_rdy got=%b exp=0", data_out_rdy); end
        checks++; if (drop_cnt !== d0 + 1 || err_cnt !== 16'd2) begin errors++; $display("FAIL sum_bad_drop drops=%0d err=%0d exp=1/2", drop_cnt - d0, err_cnt); end
    endtask
`endif

    task automatic test_reset_mid_frame();
        int d0;
        send_payload(8'h01, 5);
        d0 = drop_cnt;
        @(negedge clk);
        data_rdy = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (data_out_rdy !== 1'b0 || fields_out !== '0) begin errors++; $display("FAIL midrst_outputs rdy=%b fields=%h exp=0/0", data_out_rdy, fields_out); end
        checks++; if (err_cnt !== 16'd0 || frame_drop !== 1'b0) begin errors++; $display("FAIL midrst_err err=%0d drop=%b exp=0/0", err_cnt, frame_drop); end
        checks++; if (state_dbg !== 2'(HUNT)) begin errors++; $display("FAIL midrst_state got=%0d exp=%0d", state_dbg, HUNT); end
        repeat (2) @(negedge clk);
        checks++; if (drop_cnt !== d0) begin errors++; $display("FAIL midrst_no_pulse got=%0d exp=0", drop_cnt - d0); end
        send_frame(8'h11, 1'b0);
        checks++; if (data_out_rdy !== 1'b1) begin errors++; $display("FAIL midrst_next_rdy got=%b exp=1", data_out_rdy); end
        checks++; if (fields_out[0 +: FW] !== 32'h11121314) begin errors++; $display("FAIL midrst_next_field0 got=%h exp=11121314", fields_out[0 +: FW]); end
        checks++; if (fields_out[6*FW +: FW] !== 32'h292A2B2C) begin errors++; $display("FAIL midrst_next_field6 got=%h exp=292A2B2C", fields_out[6*FW +: FW]); end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_overflow();
        test_timeout();
`ifdef PARSE_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
